// File: rtl/keccak_chi_masked_pipe.sv
// keccak_chi_masked_pipe: pipelined d-th order masked Keccak chi over W rows.
// Stage 1 registers (d+1)^2 expanded shares per output bit (cross-share ANDs plus
// symmetric fresh masks); stage 2 XOR-compresses them back to d+1 shares.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input row-set handshake; accepted only while rnd_valid=1
//   rnd_valid, rnd       fresh masks, W*5*d*(d+1)/2 bits, consumed once per accept
//   in_sh                share s of bit k of row w at (w*5+k)*(d+1)+s
//   out_valid/out_ready  output handshake; out_sh uses the in_sh layout
module keccak_chi_masked_pipe #(
  parameter int d = 4,
  parameter int W = 1,
  parameter int OUT_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rnd_valid,
  input  logic [W*5*(d+1)-1:0]     in_sh,
  input  logic [W*5*d*(d+1)/2-1:0] rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W*5*(d+1)-1:0]     out_sh
);
  localparam int S = d + 1;
  localparam int P = d * (d + 1) / 2;
  localparam int R1 = 5 * P;
  localparam int N = W * 5 * S;
  localparam int E = N * S;
  logic [E-1:0] ex, s1_sh;
  logic [N-1:0] cmp;
  logic s1_v, adv1, accept;
  function automatic logic sh(input logic [N-1:0] v, input int w, input int k, input int t);
    return v[(w*5+k)*S+t];
  endfunction
  function automatic logic mk(input logic [W*R1-1:0] r, input int w, input int k, input int i, input int j);
    int lo = i < j ? i : j;
    int hi = i < j ? j : i;
    if (i == j) return 1'b0;
    return r[w*R1+k*P+lo+hi*(hi-1)/2];
  endfunction
  // The linear share x_i enters once, at column j=0, so each output share carries it
  // exactly once and the share sum is exact for any d. The complement of chi is
  // applied to the share-0 operand only.
  function automatic logic xb(input logic [N-1:0] v, input logic [W*R1-1:0] r,
                              input int w, input int k, input int i, input int j);
    int s = (i + j) % S;
    logic lin = j == 0 ? sh(v, w, k, i) : 1'b0;
    logic nl = k == 0 ? (sh(v, w, 1, i) ^ (i == 0)) & sh(v, w, 2, j) ^ mk(r, w, 0, i, j)
             : k == 1 ? (sh(v, w, 2, j) ^ (j == 0)) & sh(v, w, 3, i) ^ mk(r, w, 1, i, j)
             : k == 2 ? (sh(v, w, 3, i) ^ (i == 0)) & sh(v, w, 4, j) ^ mk(r, w, 2, i, j)
             : k == 3 ? (sh(v, w, 4, j) ^ (j == 0)) & sh(v, w, 0, s) ^ mk(r, w, 3, j, s)
             :          (sh(v, w, 0, s) ^ (s == 0)) & sh(v, w, 1, i) ^ mk(r, w, 4, i, s);
    return lin ^ nl;
  endfunction
  always_comb begin
    ex = '0;
    for (int w = 0; w < W; w++)
      for (int k = 0; k < 5; k++)
        for (int i = 0; i < S; i++)
          for (int j = 0; j < S; j++)
            ex[((w*5+k)*S+i)*S+j] = xb(in_sh, rnd, w, k, i, j);
  end
  always_comb begin
    cmp = '0;
    for (int n = 0; n < N; n++) cmp[n] = ^s1_sh[n*S +: S];
  end
  assign in_ready = ~s1_v | adv1;
  assign accept = in_valid & rnd_valid & in_ready;
  // Stage-1 register is the glitch barrier between the AND terms and the XOR tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_sh <= '0;
    end else begin
      s1_v <= accept | (s1_v & ~adv1);
      if (accept) s1_sh <= ex;
    end
  end
  if (OUT_REG != 0) begin : g_out_reg
    logic s2_v;
    logic [N-1:0] s2_sh;
    assign adv1 = s1_v & (~s2_v | out_ready);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_v <= 1'b0;
        s2_sh <= '0;
      end else begin
        s2_v <= adv1 | (s2_v & ~out_ready);
        if (adv1) s2_sh <= cmp;
      end
    end
    assign out_valid = s2_v;
    assign out_sh = s2_sh;
  end else begin : g_out_comb
    assign adv1 = s1_v & out_ready;
    assign out_valid = s1_v;
    assign out_sh = cmp;
  end
endmodule
